// File: rtl/ula_op_controller.sv
// Command sequencer in front of the ULA logic datapath: logic ops and ADD finish in one
// cycle, MUL runs an iterative shift-add, and the result is held until the consumer takes it.
module ula_op_controller #(
    parameter int MUL_STEPS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_out,
    output logic        res_zero,
    output logic        res_err,
    output logic        busy
);

    localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_ADD  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic is_zero16(input logic [15:0] v);
        return (v == 16'h0000);
    endfunction

    // Single-cycle result as {err, value}; MUL never takes this path.
    function automatic logic [16:0] direct_result(input logic [2:0] op,
                                                  input logic [7:0] a,
                                                  input logic [7:0] b);
        logic [16:0] r;
        case (op)
            OP_AND:  r = {1'b0, 8'h00, a & b};
            OP_OR:   r = {1'b0, 8'h00, a | b};
            OP_NAND: r = {1'b0, 8'h00, ~(a & b)};
            OP_XOR:  r = {1'b0, 8'h00, a ^ b};
            OP_NOR:  r = {1'b0, 8'h00, ~(a | b)};
            OP_ADD:  r = {1'b0, 7'h00, {1'b0, a} + {1'b0, b}};
            default: r = {1'b1, 16'h0000};
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;
    logic [15:0]      mcand_q, mcand_d;
    logic [7:0]       mplier_q, mplier_d;
    logic [15:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      res_out_q, res_out_d;
    logic             res_zero_q, res_zero_d;
    logic             res_err_q, res_err_d;

    logic [15:0]      partial_s;
    logic [15:0]      acc_sum_s;
    logic [16:0]      direct_s;
    logic             accept_s;

    // Next-state, datapath and output-register computation.
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        res_out_d  = res_out_q;
        res_zero_d = res_zero_q;
        res_err_d  = res_err_q;

        partial_s = mplier_q[0] ? mcand_q : 16'h0000;
        acc_sum_s = acc_q + partial_s;
        direct_s  = direct_result(cmd_op, cmd_a, cmd_b);
        // cmd_ready_q is only ever high while idle, and stays low for the reset cycle.
        accept_s  = cmd_valid & cmd_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (cmd_op == OP_MUL) begin
                        mcand_d  = {8'h00, cmd_a};
                        mplier_d = cmd_b;
                        acc_d    = 16'h0000;
                        cnt_d    = '0;
                        state_d  = ST_MUL;
                    end else begin
                        res_out_d  = direct_s[15:0];
                        res_err_d  = direct_s[16];
                        res_zero_d = is_zero16(direct_s[15:0]);
                        state_d    = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_d    = acc_sum_s;
                mcand_d  = {mcand_q[14:0], 1'b0};
                mplier_d = {1'b0, mplier_q[7:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    res_out_d  = acc_sum_s;
                    res_err_d  = 1'b0;
                    res_zero_d = is_zero16(acc_sum_s);
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mcand_q     <= 16'h0000;
            mplier_q    <= 8'h00;
            acc_q       <= 16'h0000;
            cnt_q       <= '0;
            res_out_q   <= 16'h0000;
            res_zero_q  <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_out_q   <= res_out_d;
            res_zero_q  <= res_zero_d;
            res_err_q   <= res_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign res_out   = res_out_q;
    assign res_zero  = res_zero_q;
    assign res_err   = res_err_q;

endmodule
